// File: rtl/chu_mmio_arb_pkg.sv
// Shared types and constants for the FPro MMIO bus arbiter.
//   arb_state_t : arbiter FSM states
//   MMIO_AW/DW  : default MMIO address/data widths
//   idx_width() : bits needed to index n masters (at least 1)
package chu_mmio_arb_pkg;

  localparam int unsigned MMIO_AW = 21;
  localparam int unsigned MMIO_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chu_mmio_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per requester
//   last    : index of the most recently served requester
//   winner  : first requester found scanning last+1, last+2, ... modulo N
//   any_req : at least one request is pending (winner is only valid then)
module chu_rr_pick
  import chu_mmio_arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned GW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic [GW-1:0] winner,
  output logic          any_req
);

  int unsigned idx;
  logic        found;

  always_comb begin
    winner  = '0;
    found   = 1'b0;
    idx     = 0;
    any_req = |req;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last) + i) % N;
      if (!found && req[idx[GW-1:0]]) begin
        winner = idx[GW-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chu_mmio_arbiter.sv
// Round-robin arbiter sharing one FPro MMIO bus between N_M masters.
// One transaction per grant (IDLE -> ISSUE -> RESP), optional lock keeps the
// grant for read-modify-write sequences. All outputs are registered.
//   clk, reset            : clock, async active-low reset
//   m_req/m_wr/m_lock     : per-master request, write flag, lock
//   m_addr/m_wr_data      : per-master command, packed, master i at [i*W +: W]
//   m_gnt/m_ack           : one-hot grant, one-cycle completion pulse
//   m_rd_data             : data of the last completed read (shared)
//   mmio_*                : bus towards chu_mmio_controller
module chu_mmio_arbiter
  import chu_mmio_arb_pkg::*;
#(
  parameter int unsigned N_M = 2,
  parameter int unsigned AW  = MMIO_AW,
  parameter int unsigned DW  = MMIO_DW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_M-1:0]  m_req,
  input  logic [N_M-1:0]  m_wr,
  input  logic [N_M-1:0]  m_lock,
  input  logic [N_M*AW-1:0] m_addr,
  input  logic [N_M*DW-1:0] m_wr_data,
  output logic [N_M-1:0]  m_gnt,
  output logic [N_M-1:0]  m_ack,
  output logic [DW-1:0]   m_rd_data,
  output logic            mmio_cs,
  output logic            mmio_wr,
  output logic            mmio_rd,
  output logic [AW-1:0]   mmio_addr,
  output logic [DW-1:0]   mmio_wr_data,
  input  logic [DW-1:0]   mmio_rd_data
);

  localparam int unsigned GW = idx_width(N_M);

  arb_state_t     state_q, state_d;
  logic [GW-1:0]  owner_q, owner_d;
  logic [GW-1:0]  last_q, last_d;
  logic           lock_q, lock_d;
  logic [N_M-1:0] gnt_q, gnt_d;
  logic [N_M-1:0] ack_q, ack_d;
  logic [DW-1:0]  rd_data_q, rd_data_d;
  logic           cs_q, cs_d;
  logic           wr_q, wr_d;
  logic           rd_q, rd_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;

  logic [GW-1:0]  pick_idx;
  logic           any_req;
  logic           grant;
  logic [GW-1:0]  grant_idx;

  chu_rr_pick #(
    .N  (N_M),
    .GW (GW)
  ) u_pick (
    .req     (m_req),
    .last    (last_q),
    .winner  (pick_idx),
    .any_req (any_req)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    lock_d    = lock_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    rd_data_d = rd_data_q;
    cs_d      = 1'b0;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    grant     = 1'b0;
    grant_idx = pick_idx;

    unique case (state_q)
      IDLE: begin
        if (lock_q) begin
          if (m_req[owner_q]) begin
            grant     = 1'b1;
            grant_idx = owner_q;
          end else begin
            // Owner went quiet: drop the lock, arbitrate from the next cycle.
            lock_d = 1'b0;
            gnt_d  = '0;
          end
        end else if (any_req) begin
          grant = 1'b1;
        end

        if (grant) begin
          state_d          = ISSUE;
          owner_d          = grant_idx;
          gnt_d            = '0;
          gnt_d[grant_idx] = 1'b1;
          cs_d             = 1'b1;
          wr_d             = m_wr[grant_idx];
          rd_d             = ~m_wr[grant_idx];
          addr_d           = m_addr[grant_idx*AW +: AW];
          wdata_d          = m_wr_data[grant_idx*DW +: DW];
        end
      end

      ISSUE: begin
        state_d        = RESP;
        ack_d[owner_q] = 1'b1;
        if (rd_q) rd_data_d = mmio_rd_data;
      end

      RESP: begin
        state_d = IDLE;
        last_d  = owner_q;
        lock_d  = m_lock[owner_q];
        if (!m_lock[owner_q]) gnt_d = '0;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        lock_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= GW'(N_M - 1);
      lock_q    <= 1'b0;
      gnt_q     <= '0;
      ack_q     <= '0;
      rd_data_q <= '0;
      cs_q      <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      lock_q    <= lock_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      rd_data_q <= rd_data_d;
      cs_q      <= cs_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign m_gnt        = gnt_q;
  assign m_ack        = ack_q;
  assign m_rd_data    = rd_data_q;
  assign mmio_cs      = cs_q;
  assign mmio_wr      = wr_q;
  assign mmio_rd      = rd_q;
  assign mmio_addr    = addr_q;
  assign mmio_wr_data = wdata_q;

endmodule

// File: tb/tb_chu_mmio_arbiter.sv
// Directed bench for chu_mmio_arbiter with two masters.
module tb_chu_mmio_arbiter;

  localparam int unsigned N_M = 2;
  localparam int unsigned AW  = 21;
  localparam int unsigned DW  = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N_M-1:0]    m_req = '0;
  logic [N_M-1:0]    m_wr = '0;
  logic [N_M-1:0]    m_lock = '0;
  logic [N_M*AW-1:0] m_addr = '0;
  logic [N_M*DW-1:0] m_wr_data = '0;
  logic [N_M-1:0]    m_gnt;
  logic [N_M-1:0]    m_ack;
  logic [DW-1:0]     m_rd_data;
  logic              mmio_cs;
  logic              mmio_wr;
  logic              mmio_rd;
  logic [AW-1:0]     mmio_addr;
  logic [DW-1:0]     mmio_wr_data;
  logic [DW-1:0]     mmio_rd_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  chu_mmio_arbiter #(
    .N_M (N_M),
    .AW  (AW),
    .DW  (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m_req        (m_req),
    .m_wr         (m_wr),
    .m_lock       (m_lock),
    .m_addr       (m_addr),
    .m_wr_data    (m_wr_data),
    .m_gnt        (m_gnt),
    .m_ack        (m_ack),
    .m_rd_data    (m_rd_data),
    .mmio_cs      (mmio_cs),
    .mmio_wr      (mmio_wr),
    .mmio_rd      (mmio_rd),
    .mmio_addr    (mmio_addr),
    .mmio_wr_data (mmio_wr_data),
    .mmio_rd_data (mmio_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int m, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    m_wr[m]               = wr;
    m_addr[m*AW +: AW]    = addr;
    m_wr_data[m*DW +: DW] = data;
  endtask

  // One unlocked transaction from master m, starting and ending in IDLE.
  task automatic run_single(input int m, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data);
    set_cmd(m, wr, addr, data);
    m_req[m] = 1'b1;
    tick();
    check("single_cs", 64'(mmio_cs), 64'd1);
    check("single_gnt", 64'(m_gnt), 64'(1 << m));
    tick();
    check("single_ack", 64'(m_ack), 64'(1 << m));
    m_req[m] = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_req = '0;
    m_lock = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_gnt", 64'(m_gnt), 64'd0);
    check("rst_ack", 64'(m_ack), 64'd0);
    check("rst_cs", 64'(mmio_cs), 64'd0);
    check("rst_rdata", 64'(m_rd_data), 64'd0);
    reset = 1'b1;
    tick();

    // 1. Single read by master 0
    set_cmd(0, 1'b0, 21'h000C0, 32'h0);
    mmio_rd_data = 32'hDEAD_BEEF;
    m_req = 2'b01;
    tick();
    check("t1_cs", 64'(mmio_cs), 64'd1);
    check("t1_rd", 64'(mmio_rd), 64'd1);
    check("t1_wr", 64'(mmio_wr), 64'd0);
    check("t1_addr", 64'(mmio_addr), 64'h000C0);
    check("t1_gnt", 64'(m_gnt), 64'd1);
    check("t1_noack", 64'(m_ack), 64'd0);
    tick();
    check("t1_ack", 64'(m_ack), 64'd1);
    check("t1_cs_off", 64'(mmio_cs), 64'd0);
    check("t1_rdata", 64'(m_rd_data), 64'hDEAD_BEEF);
    m_req = 2'b00;
    tick();
    check("t1_ack_off", 64'(m_ack), 64'd0);
    check("t1_gnt_off", 64'(m_gnt), 64'd0);
    mmio_rd_data = 32'h0;
    tick();
    tick();
    check("t1_rdata_hold", 64'(m_rd_data), 64'hDEAD_BEEF);

    // 4. A write leaves the last read data alone
    mmio_rd_data = 32'h1234_5678;
    run_single(0, 1'b0, 21'h00010, 32'h0);
    check("t4_rdata", 64'(m_rd_data), 64'h1234_5678);
    mmio_rd_data = 32'hAAAA_AAAA;
    run_single(1, 1'b1, 21'h00020, 32'hFFFF_FFFF);
    check("t4_rdata_kept", 64'(m_rd_data), 64'h1234_5678);

    // 2. Contention after reset: 0,1,0,1,... one transaction per 3 cycles
    do_reset();
    set_cmd(0, 1'b1, 21'h00010, 32'd0);
    set_cmd(1, 1'b1, 21'h00020, 32'd0);
    m_req = 2'b11;
    for (int t = 0; t < 6; t++) begin
      m_wr_data = {32'(t + 1), 32'(t + 1)};
      tick();
      check("t2_gnt", 64'(m_gnt), 64'(1 << (t % 2)));
      check("t2_wr", 64'(mmio_wr), 64'd1);
      check("t2_addr", 64'(mmio_addr), (t % 2 == 0) ? 64'h10 : 64'h20);
      check("t2_data", 64'(mmio_wr_data), 64'(t + 1));
      tick();
      check("t2_ack", 64'(m_ack), 64'(1 << (t % 2)));
      check("t2_no_wr_rd", 64'(mmio_wr & mmio_rd), 64'd0);
      tick();
      check("t2_idle_cs", 64'(mmio_cs), 64'd0);
    end
    m_req = 2'b00;
    tick();

    // 3. Lock: three back-to-back transactions for master 1
    run_single(0, 1'b1, 21'h00010, 32'h0);  // last grant -> 0, master 1 wins next
    set_cmd(1, 1'b1, 21'h00030, 32'h55);
    m_lock = 2'b10;
    m_req  = 2'b11;
    for (int t = 0; t < 3; t++) begin
      if (t == 2) m_lock = 2'b00;
      tick();
      check("t3_gnt", 64'(m_gnt), 64'd2);
      check("t3_cs", 64'(mmio_cs), 64'd1);
      tick();
      check("t3_ack", 64'(m_ack), 64'd2);
      tick();
      if (t < 2) check("t3_hold_gnt", 64'(m_gnt), 64'd2);
    end
    m_req = 2'b01;
    check("t3_released", 64'(m_gnt), 64'd0);
    tick();
    check("t3_m0_gnt", 64'(m_gnt), 64'd1);
    tick();
    check("t3_m0_ack", 64'(m_ack), 64'd1);
    m_req = 2'b00;
    tick();

    // 5. Reset during ISSUE aborts everything asynchronously
    set_cmd(0, 1'b0, 21'h00040, 32'h0);
    mmio_rd_data = 32'hCAFE_0001;
    m_req = 2'b01;
    tick();
    check("t5_cs_before", 64'(mmio_cs), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_cs", 64'(mmio_cs), 64'd0);
    check("t5_rd", 64'(mmio_rd), 64'd0);
    check("t5_wr", 64'(mmio_wr), 64'd0);
    check("t5_gnt", 64'(m_gnt), 64'd0);
    m_req = 2'b00;
    tick();
    check("t5_ack", 64'(m_ack), 64'd0);
    check("t5_rdata", 64'(m_rd_data), 64'd0);
    reset = 1'b1;
    set_cmd(1, 1'b0, 21'h00050, 32'h0);
    m_req = 2'b11;
    tick();
    check("t5_prio", 64'(m_gnt), 64'd1);
    tick();
    m_req = 2'b00;
    tick();

    // 6. Request withdrawn before the sampling edge is ignored
    m_req = 2'b10;
    #3;
    m_req = 2'b00;
    tick();
    check("t6_cs", 64'(mmio_cs), 64'd0);
    check("t6_gnt", 64'(m_gnt), 64'd0);
    tick();
    check("t6_ack", 64'(m_ack), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
